// File: rtl/calc_sequencer_if.sv
// Bundle of the calculator sequencer's command, register-file, ALU and result signals.
// Handshake: a command transfers on a rising clock edge where cmd_valid && cmd_ready are both high;
// cmd_ready depends only on sequencer state (never on cmd_valid), and cmd_* are sampled only on that edge.
// res_valid is a one-cycle pulse with no back-pressure.
// state_dbg exposes the sequencer FSM state for checkers.
interface calc_sequencer_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2,
  parameter int OP_W   = 3
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [ADDR_W-1:0] cmd_dst;
  logic [ADDR_W-1:0] cmd_src_a;
  logic [ADDR_W-1:0] cmd_src_b;
  logic [ADDR_W-1:0] rf_rd_addr;
  logic [DATA_W-1:0] rf_rd_data;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_we_addr;
  logic [DATA_W-1:0] rf_we_data;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic [2:0]        state_dbg;

  // Environment side: command source, register file read data, ALU result.
  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, rf_rd_data, alu_result,
    input  cmd_ready, rf_rd_addr, rf_we, rf_we_addr, rf_we_data, alu_op, alu_a, alu_b,
           res_valid, res_data, state_dbg
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, rf_rd_data, alu_result,
    output cmd_ready, rf_rd_addr, rf_we, rf_we_addr, rf_we_data, alu_op, alu_a, alu_b,
           res_valid, res_data, state_dbg
  );
endinterface

// File: rtl/calc_sequencer.sv
// calc_sequencer: one command per handshake, operands read over the single register-file read port,
// ALU driven from latched operands, result written back in WB.
// Sequence: IDLE -> RD_A -> RD_B -> EXEC -> WB -> IDLE.
// Optional macro CALC_SEQ_FWD_EN: when src_b == src_a, RD_B is skipped and operand B reuses the RD_A read.
module calc_sequencer #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2,
  parameter int OP_W   = 3
) (
  input  logic           clk,
  input  logic           rst,
  calc_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [OP_W-1:0]   op_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W-1:0] src_a_q;
  logic [ADDR_W-1:0] src_b_q;
  logic [DATA_W-1:0] opa_q;
  logic [DATA_W-1:0] opb_q;
  logic [DATA_W-1:0] res_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a command is taken only from IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.cmd_valid) state_d = S_RD_A;
      S_RD_A: begin
`ifdef CALC_SEQ_FWD_EN
        state_d = (src_b_q == src_a_q) ? S_EXEC : S_RD_B;
`else
        state_d = S_RD_B;
`endif
      end
      S_RD_B:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Command latch, operand capture and result capture, each in its own state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      dst_q   <= '0;
      src_a_q <= '0;
      src_b_q <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            op_q    <= bus.cmd_op;
            dst_q   <= bus.cmd_dst;
            src_a_q <= bus.cmd_src_a;
            src_b_q <= bus.cmd_src_b;
          end
        end
        S_RD_A: begin
          opa_q <= bus.rf_rd_data;
`ifdef CALC_SEQ_FWD_EN
          if (src_b_q == src_a_q) opb_q <= bus.rf_rd_data;
`endif
        end
        S_RD_B: opb_q <= bus.rf_rd_data;
        S_EXEC: res_q <= bus.alu_result;
        default: ;
      endcase
    end
  end

  // Outputs come straight from state and latched values, so the ALU inputs never glitch.
  assign bus.cmd_ready  = (state_q == S_IDLE);
  assign bus.rf_rd_addr = (state_q == S_RD_B) ? src_b_q : src_a_q;
  assign bus.rf_we      = (state_q == S_WB);
  assign bus.rf_we_addr = dst_q;
  assign bus.rf_we_data = res_q;
  assign bus.alu_op     = op_q;
  assign bus.alu_a      = opa_q;
  assign bus.alu_b      = opb_q;
  assign bus.res_valid  = (state_q == S_WB);
  assign bus.res_data   = res_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: register file and ALU environment, command-level model, per-cycle compare.
module tb_calc_sequencer;
  localparam int DW = 4;
  localparam int AW = 2;
  localparam int OW = 3;
`ifdef CALC_SEQ_FWD_EN
  localparam int LAT_SAME = 3;
`else
  localparam int LAT_SAME = 4;
`endif

  logic clk;
  logic rst;
  calc_sequencer_if #(.DATA_W(DW), .ADDR_W(AW), .OP_W(OW)) bus ();

  calc_sequencer #(.DATA_W(DW), .ADDR_W(AW), .OP_W(OW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  // ---------------- environment: register file + ALU ----------------
  logic [DW-1:0] rf [4];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  assign bus.rf_rd_data = rf[bus.rf_rd_addr];

  function automatic logic [DW-1:0] alu_fn(logic [OW-1:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
    case (op)
      3'd0:    alu_fn = a + b;
      3'd1:    alu_fn = a - b;
      default: alu_fn = '0;
    endcase
  endfunction

  assign bus.alu_result = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);

  initial begin
    for (int i = 0; i < 4; i++) rf[i] = '0;
    forever begin
      @(posedge clk);
      if (pre_we)         rf[pre_addr]       <= pre_data;
      else if (bus.rf_we) rf[bus.rf_we_addr] <= bus.rf_we_data;
    end
  end

  // ---------------- scoreboard / counters ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- command-level model ----------------
  logic [DW-1:0] exp_q [$];
  int            acc_q [$];
  int            commit_q [$];
  int            mdl_regs [4];
  int            cyc = 0;
  bit            pending = 0;
  int            wb_edge = 0;
  int            m_dst = 0;
  int            m_op = 0;
  int            m_a = 0;
  int            m_b = 0;
  int            last_res = 0;

  function automatic int model_alu(int op, int a, int b);
    if (op == 0)      model_alu = (a + b) % 16;
    else if (op == 1) model_alu = (a - b + 16) % 16;
    else              model_alu = 0;
  endfunction

  initial begin
    for (int i = 0; i < 4; i++) mdl_regs[i] = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        pending  = 0;
        last_res = 0;
        exp_q.delete();
      end else begin
        cyc++;
        if (pre_we) mdl_regs[pre_addr] = int'(pre_data);
        if (pending && cyc == wb_edge) begin
          last_res = int'(exp_q.pop_front());
          mdl_regs[m_dst] = last_res;
          commit_q.push_back(cyc);
          pending = 0;
        end else if (!pending && bus.cmd_valid) begin
          m_op  = int'(bus.cmd_op);
          m_dst = int'(bus.cmd_dst);
          m_a   = mdl_regs[bus.cmd_src_a];
          m_b   = mdl_regs[bus.cmd_src_b];
          exp_q.push_back(DW'(model_alu(m_op, m_a, m_b)));
          wb_edge = (bus.cmd_src_a == bus.cmd_src_b) ? cyc + LAT_SAME : cyc + 4;
          acc_q.push_back(cyc);
          pending = 1;
        end
      end
    end
  end

  // Per-cycle compare against the model.
  int we_cnt = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (bus.rf_we) we_cnt++;
      check("cmd_ready", bus.cmd_ready, !pending);
      if (pending && cyc == wb_edge - 1) begin
        check("wb_rf_we", bus.rf_we, 1);
        check("wb_res_valid", bus.res_valid, 1);
        check("wb_addr", bus.rf_we_addr, m_dst);
        check("wb_data", bus.rf_we_data, exp_q[0]);
        check("wb_res_data", bus.res_data, exp_q[0]);
      end else begin
        check("idle_rf_we", bus.rf_we, 0);
        check("idle_res_valid", bus.res_valid, 0);
        check("res_data_hold", bus.res_data, last_res);
      end
      if (pending && cyc == wb_edge - 2) begin
        check("exec_alu_op", bus.alu_op, m_op);
        check("exec_alu_a", bus.alu_a, m_a);
        check("exec_alu_b", bus.alu_b, m_b);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    while (pending && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", pending, 0);
  endtask

  task automatic preload(input int addr, input int data);
    @(negedge clk);
    #1;
    pre_we   = 1'b1;
    pre_addr = AW'(addr);
    pre_data = DW'(data);
    @(posedge clk);
    #1;
    pre_we = 1'b0;
  endtask

  task automatic set_cmd(input int op, input int dst, input int a, input int b);
    bus.cmd_op    = OW'(op);
    bus.cmd_dst   = AW'(dst);
    bus.cmd_src_a = AW'(a);
    bus.cmd_src_b = AW'(b);
  endtask

  task automatic scramble_cmd();
    set_cmd($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
  endtask

  // Returns #1 after the accept edge.
  task automatic send_cmd(input int op, input int dst, input int a, input int b);
    wait_idle();
    @(negedge clk);
    #1;
    set_cmd(op, dst, a, b);
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    scramble_cmd();
    check("ready_low_after_accept", bus.cmd_ready, 0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int we0;
    int sz;
    int k;
    rst = 1'b1;
    pre_we = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    bus.cmd_valid = 1'b0;
    set_cmd(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_rf_we", bus.rf_we, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_rd_addr", bus.rf_rd_addr, 0);
    check("rst_we_addr", bus.rf_we_addr, 0);
    check("rst_we_data", bus.rf_we_data, 0);
    check("rst_alu_a", bus.alu_a, 0);
    #1 rst = 1'b0;

    // 1: add R0 = R1 + R2 = 3 + 5
    preload(1, 3);
    preload(2, 5);
    send_cmd(0, 0, 1, 2);
    wait_idle();
    check("t1_r0", rf[0], 8);
    check("t1_res_data", bus.res_data, 8);
    check("t1_latency", commit_q[commit_q.size()-1] - acc_q[acc_q.size()-1], 4);

    // 2: sub R3 = R1 - R2 = 3 - 5 wraps to 14, single write pulse
    we0 = we_cnt;
    send_cmd(1, 3, 1, 2);
    wait_idle();
    check("t2_r3", rf[3], 4'he);
    check("t2_r1", rf[1], 3);
    check("t2_r2", rf[2], 5);
    check("t2_we_pulses", we_cnt - we0, 1);

    // 3: cmd_valid held high across two commands
    wait_idle();
    @(negedge clk);
    #1;
    set_cmd(0, 0, 1, 2);
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    set_cmd(1, 3, 2, 1);
    sz = acc_q.size();
    k = 0;
    while (acc_q.size() == sz && k < 10) begin
      @(posedge clk);
      #1;
      k++;
    end
    bus.cmd_valid = 1'b0;
    check("t3_second_accepted", acc_q.size(), sz + 1);
    check("t3_gap", acc_q[acc_q.size()-1] - acc_q[acc_q.size()-2], 5);
    wait_idle();
    check("t3_r0", rf[0], 8);
    check("t3_r3", rf[3], 2);

    // 4: same source twice, dst equals source: R1 = 7 + 7
    preload(1, 7);
    send_cmd(0, 1, 1, 1);
    wait_idle();
    check("t4_r1", rf[1], 14);
    check("t4_latency", commit_q[commit_q.size()-1] - acc_q[acc_q.size()-1], LAT_SAME);

    // 5: reset during EXEC aborts the write to R2
    send_cmd(0, 2, 1, 1);
    k = 0;
    while (cyc != wb_edge - 2 && k < 6) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("t5_reached_exec", bus.state_dbg, 3);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_ready", bus.cmd_ready, 1);
    check("t5_rst_we", bus.rf_we, 0);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_r2", rf[2], 5);
    check("t5_ready_after", bus.cmd_ready, 1);
    check("t5_res_data", bus.res_data, 0);

    // 6: command inputs change during RD_B; R0 = R2 - R1 = 5 - 14 wraps to 7
    send_cmd(1, 0, 2, 1);
    @(posedge clk);
    #1;
    set_cmd(0, 3, 3, 3);
    wait_idle();
    check("t6_r0", rf[0], 7);
    check("t6_r3", rf[3], 2);

    // final register file against model and hand values
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) check("final_vs_model", rf[i], mdl_regs[i]);
    check("final_r0", rf[0], 7);
    check("final_r1", rf[1], 14);
    check("final_r2", rf[2], 5);
    check("final_r3", rf[3], 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
